sigma_delta_decimator: RTL and testbench

//  Receive-side counterpart of first_order_dac: turns a 1-bit sigma-delta stream back into
//  16-bit unsigned samples on the same i_func scale (duty d -> value d*65536).
//  Two-stage CIC (sinc2) filter decimates by R = 2^LOG2_R. Used on comparator/loopback

---
 rtl/sigma_delta_pkg.sv | 17 +
 rtl/cic_comb_stage.sv | 26 ++
 rtl/sigma_delta_decimator.sv | 117 +++++++++++
 tb/tb_sigma_delta_decimator.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_delta_pkg.sv
// Shared constants and width helpers for the sigma-delta decimator.
package sigma_delta_pkg;

  localparam int DATA_W = 16;

  // Accumulator width for a two-stage CIC: input growth of 2*LOG2_R bits plus
  // one bit so that full scale (R^2) is representable.
  function automatic int acc_width(input int log2_r);
    return 2 * log2_r + 1;
  endfunction

  // Left shift that maps the comb range 0..R^2 onto the 16-bit output scale.
  function automatic int out_shift(input int log2_r);
    return (2 * log2_r <= DATA_W) ? (DATA_W - 2 * log2_r) : 0;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb: holds the previous decimated input and presents the
// difference against it. The delay register advances only on i_en.
module cic_comb_stage
  import sigma_delta_pkg::*;
#(
  parameter int W = acc_width(5)
) (
  input  logic         i_clk,
  input  logic         i_res,
  input  logic         i_en,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_diff
);

  logic [W-1:0] dly;

  // Difference is combinational so two stages can be chained in one clock.
  assign o_diff = i_x - dly;

  // Capture the current input as the delay for the next decimated sample.
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) dly <= '0;
    else if (i_en) dly <= i_x;
  end

endmodule

// File: rtl/sigma_delta_decimator.sv
// Sinc2 CIC decimator: turns a 1-bit sigma-delta stream into 16-bit unsigned
// samples (duty d -> d*65536) with a valid/ready output and sticky overrun.
module sigma_delta_decimator
  import sigma_delta_pkg::*;
#(
  parameter int LOG2_R  = 5,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_res,
  input  logic              i_ce,
  input  logic              i_bit,
  input  logic              i_ready,
  input  logic              i_clr_ovr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_overrun
);

  localparam int W     = acc_width(LOG2_R);
  localparam int SHIFT = out_shift(LOG2_R);
  // Full scale R^2 is the only value that needs the top accumulator bit.
  localparam logic [W-1:0] FULL = {1'b1, {(W-1){1'b0}}};

  logic [1:0]        sync_q;
  logic              x;
  logic [W-1:0]      int1, int2;
  logic [LOG2_R-1:0] cnt;
  logic              strobe, strobe_d;
  logic [W-1:0]      comb1_diff, comb2_diff, comb2_q;
  logic [DATA_W-1:0] scaled;
  logic [1:0]        warm_cnt;
  logic              load;

  // Two-flop synchroniser for the asynchronous bitstream.
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], i_bit};
  end

  assign x = SYNC_EN ? sync_q[1] : i_bit;

  // Integrators, decimation counter and decimate strobe, all gated by i_ce.
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      int1   <= '0;
      int2   <= '0;
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= i_ce && (cnt == '1);
      if (i_ce) begin
        int1 <= int1 + W'(x);
        int2 <= int2 + int1;
        cnt  <= cnt + LOG2_R'(1);
      end
    end
  end

  cic_comb_stage #(.W(W)) u_comb1 (
    .i_clk  (i_clk),
    .i_res  (i_res),
    .i_en   (strobe),
    .i_x    (int2),
    .o_diff (comb1_diff)
  );

  cic_comb_stage #(.W(W)) u_comb2 (
    .i_clk  (i_clk),
    .i_res  (i_res),
    .i_en   (strobe),
    .i_x    (comb1_diff),
    .o_diff (comb2_diff)
  );

  // Register the comb result and delay the strobe to time the scaler.
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      comb2_q  <= '0;
      strobe_d <= 1'b0;
    end else begin
      strobe_d <= strobe;
      if (strobe) comb2_q <= comb2_diff;
    end
  end

  // Scale 0..R^2 onto 16 bits; exact full scale would wrap, so saturate it.
  always_comb begin
    scaled = '0;
    if (comb2_q == FULL) scaled = '1;
    else                 scaled = DATA_W'(comb2_q[W-2:0]) << SHIFT;
  end

  assign load = strobe_d && (warm_cnt == 2'd2);

  // Warm-up discard of the first two results, then the output handshake.
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      warm_cnt  <= 2'd0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (strobe_d && (warm_cnt != 2'd2)) warm_cnt <= warm_cnt + 2'd1;
      if (load) begin
        o_data  <= scaled;
        o_valid <= 1'b1;
        if (o_valid && !i_ready) o_overrun <= 1'b1;
        else if (i_clr_ovr)      o_overrun <= 1'b0;
      end else begin
        if (o_valid && i_ready) o_valid <= 1'b0;
        if (i_clr_ovr)          o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Bench for sigma_delta_decimator (LOG2_R=5, SYNC_EN=1). A reference model
// evaluates the sinc2 response directly as a triangular weighting of the
// sampled bit history and queues expected samples for comparison.
module tb_sigma_delta_decimator;

  localparam int R = 32;

  logic        i_clk = 1'b0;
  logic        i_res = 1'b0;
  logic        i_ce = 1'b1;
  logic        i_bit = 1'b0;
  logic        i_ready = 1'b1;
  logic        i_clr_ovr = 1'b0;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_overrun;

  int checks = 0;
  int errors = 0;
  int push_cnt = 0;
  int result_idx = 0;
  int tick = 0;
  int bit_mode = 0;
  bit ce_toggle = 1'b0;
  logic [15:0] dac_acc = 16'h0;
  logic [15:0] dac_func = 16'h0;
  logic [1:0]  tb_sync = 2'b00;
  logic [15:0] exp_q[$];
  bit          samples[$];

  sigma_delta_decimator #(.LOG2_R(5), .SYNC_EN(1'b1)) dut (
    .i_clk     (i_clk),
    .i_res     (i_res),
    .i_ce      (i_ce),
    .i_bit     (i_bit),
    .i_ready   (i_ready),
    .i_clr_ovr (i_clr_ovr),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_overrun (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  function automatic int tri_f(input int k, input int j);
    return (k - 1 - j > 0) ? (k - 1 - j) : 0;
  endfunction

  // Expected output after n samples: second difference of the double sum.
  function automatic logic [15:0] model_out(input int n);
    int acc = 0;
    for (int j = n - 3 * R; j < n; j++)
      if (j >= 0 && samples[j]) acc += tri_f(n, j) - 2 * tri_f(n - R, j) + tri_f(n - 2 * R, j);
    if (acc == R * R) return 16'hFFFF;
    return 16'(acc * 64);
  endfunction

  always @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      tb_sync = 2'b00;
      samples.delete();
      result_idx = 0;
    end else begin
      if (i_ce) begin
        samples.push_back(tb_sync[1]);
        if (samples.size() % R == 0) begin
          result_idx++;
          if (result_idx > 2) begin
            exp_q.push_back(model_out(samples.size()));
            push_cnt++;
          end
        end
      end
      tb_sync = {tb_sync[0], i_bit};
    end
  end

  task automatic step();
    logic [16:0] sum;
    @(negedge i_clk);
    tick++;
    if (ce_toggle) i_ce = ~i_ce;
    case (bit_mode)
      1: i_bit = ~i_bit;
      2: if (tick % 2 == 0) i_bit = ~i_bit;
      3: begin
        sum = {1'b0, dac_acc} + {1'b0, dac_func};
        dac_acc = sum[15:0];
        i_bit = sum[16];
      end
      default: ;
    endcase
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_res = 1'b0; i_ce = 1'b1; i_ready = 1'b1; i_clr_ovr = 1'b0; i_bit = 1'b0;
    bit_mode = 0; ce_toggle = 1'b0; tick = 0; dac_acc = 16'h0;
    repeat (3) @(negedge i_clk);
    exp_q.delete();
    i_res = 1'b1;
  endtask

  task automatic wait_push(output bit ok);
    int old = push_cnt;
    ok = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      step();
      if (push_cnt != old) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int first = -1;
    logic [15:0] exp_v;
    i_res = 1'b0; i_ce = 1'b1; i_ready = 1'b1; i_clr_ovr = 1'b0; i_bit = 1'b0;
    bit_mode = 0; ce_toggle = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", o_data); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", o_overrun); end
    exp_q.delete();
    i_bit = 1'b1;
    i_res = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      step();
      if (o_valid === 1'b1 && first < 0) first = k;
      if (o_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL reset_data: sample %h with empty scoreboard", o_data); end
        else begin
          exp_v = exp_q.pop_front();
          if (o_data !== exp_v || o_data !== 16'hFFFF) begin
            errors++; $display("FAIL reset_first_sample: got %h expected %h", o_data, exp_v);
          end
        end
      end
    end
    checks++; if (first != 98) begin errors++; $display("FAIL warmup_latency: first valid at clk %0d expected 98", first); end
  endtask

  task automatic test_const(input logic bit_val, input logic [15:0] want, input int mode);
    int last = -1;
    logic [15:0] exp_v;
    apply_reset();
    i_bit = bit_val;
    bit_mode = mode;
    for (int k = 1; k <= 96 + 6 * R + 4; k++) begin
      step();
      if (o_valid === 1'b1 && i_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL const_data: sample %h with empty scoreboard", o_data); end
        else begin
          exp_v = exp_q.pop_front();
          if (o_data !== exp_v) begin errors++; $display("FAIL const_model: got %h expected %h", o_data, exp_v); end
        end
        checks++;
        if (o_data !== want) begin errors++; $display("FAIL const_value: got %h expected %h", o_data, want); end
        if (last >= 0) begin
          checks++;
          if (k - last != R) begin errors++; $display("FAIL const_period: got %0d clk expected %0d", k - last, R); end
        end
        last = k;
      end
    end
    checks++; if (exp_q.size() > 1) begin errors++; $display("FAIL const_missing: %0d samples not delivered expected <=1", exp_q.size()); end
  endtask

  task automatic test_dac_loopback();
    logic [15:0] funcs[4];
    logic [15:0] exp_v;
    funcs[0] = 16'd80; funcs[1] = 16'd31766; funcs[2] = 16'd33770; funcs[3] = 16'd65080;
    apply_reset();
    bit_mode = 3;
    for (int f = 0; f < 4; f++) begin
      dac_func = funcs[f];
      for (int k = 0; k < 1000; k++) begin
        step();
        if (o_valid === 1'b1 && i_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL dac_data: sample %h with empty scoreboard", o_data); end
          else begin
            exp_v = exp_q.pop_front();
            if (o_data !== exp_v) begin errors++; $display("FAIL dac_data: func %0d got %h expected %h", dac_func, o_data, exp_v); end
          end
        end
      end
    end
    checks++; if (exp_q.size() > 1) begin errors++; $display("FAIL dac_missing: %0d samples not delivered expected <=1", exp_q.size()); end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [15:0] exp_v;
    apply_reset();
    bit_mode = 3;
    dac_func = 16'd10000;
    for (int k = 1; k <= 170; k++) begin
      step();
      if (o_valid === 1'b1 && i_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ovr_pre: sample %h with empty scoreboard", o_data); end
        else begin
          exp_v = exp_q.pop_front();
          if (o_data !== exp_v) begin errors++; $display("FAIL ovr_pre: got %h expected %h", o_data, exp_v); end
        end
      end
    end
    i_ready = 1'b0;
    for (int k = 0; k < 3 * R; k++) begin
      dac_func = (k < R) ? 16'd40000 : (k < 2 * R) ? 16'd60000 : 16'd20000;
      step();
    end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", o_valid); end
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", o_overrun); end
    checks++;
    if (exp_q.size() == 0 || o_data !== exp_q[$]) begin
      errors++; $display("FAIL ovr_latest: got %h expected %h", o_data, (exp_q.size() == 0) ? 16'hxxxx : exp_q[$]);
    end
    // Clear requested on the very clock a further overwrite lands.
    wait_push(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_timeout: no result within budget, got none expected one"); end
    step();
    i_clr_ovr = 1'b1;
    step();
    i_clr_ovr = 1'b0;
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b expected 1", o_overrun); end
    checks++;
    if (exp_q.size() == 0 || o_data !== exp_q[$]) begin
      errors++; $display("FAIL ovr_overwrite: got %h expected %h", o_data, (exp_q.size() == 0) ? 16'hxxxx : exp_q[$]);
    end
    i_ready = 1'b1;
    step();
    exp_q.delete();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ovr_consume: o_valid got %b expected 0", o_valid); end
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", o_overrun); end
    i_clr_ovr = 1'b1;
    step();
    i_clr_ovr = 1'b0;
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", o_overrun); end
    // A new result on the consuming clock replaces the sample without overrun.
    i_ready = 1'b0;
    wait_push(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: no first result, got none expected one"); end
    wait_push(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: no second result, got none expected one"); end
    step();
    i_ready = 1'b1;
    step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", o_valid); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun: got %b expected 0", o_overrun); end
    checks++;
    if (exp_q.size() == 0 || o_data !== exp_q[$]) begin
      errors++; $display("FAIL b2b_data: got %h expected %h", o_data, (exp_q.size() == 0) ? 16'hxxxx : exp_q[$]);
    end
    exp_q.delete();
    for (int k = 0; k < 2 * R; k++) begin
      step();
      if (o_valid === 1'b1 && i_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_after: sample %h with empty scoreboard", o_data); end
        else begin
          exp_v = exp_q.pop_front();
          if (o_data !== exp_v) begin errors++; $display("FAIL b2b_after: got %h expected %h", o_data, exp_v); end
        end
      end
    end
  endtask

  task automatic test_ce_toggle();
    int first = -1;
    int last = -1;
    logic [15:0] exp_v;
    apply_reset();
    ce_toggle = 1'b1;
    bit_mode = 2;
    for (int k = 1; k <= 193 + 3 * 2 * R + 2; k++) begin
      step();
      if (o_valid === 1'b1 && i_ready === 1'b1) begin
        if (first < 0) first = k;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ce_data: sample %h with empty scoreboard", o_data); end
        else begin
          exp_v = exp_q.pop_front();
          if (o_data !== exp_v || o_data !== 16'h8000) begin errors++; $display("FAIL ce_data: got %h expected %h", o_data, exp_v); end
        end
        if (last >= 0) begin
          checks++;
          if (k - last != 2 * R) begin errors++; $display("FAIL ce_period: got %0d clk expected %0d", k - last, 2 * R); end
        end
        last = k;
      end
    end
    checks++; if (first != 193) begin errors++; $display("FAIL ce_latency: first valid at clk %0d expected 193", first); end
    // Hold a sample pending, then reset in the middle of the next frame.
    i_ready = 1'b0;
    for (int k = 0; k < 2 * R + 10; k++) step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ce_pending: o_valid got %b expected 1", o_valid); end
    i_res = 1'b0;
    #1;
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL midreset_data: got %h expected 0000", o_data); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", o_valid); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL midreset_overrun: got %b expected 0", o_overrun); end
    repeat (2) @(negedge i_clk);
    exp_q.delete();
    i_ready = 1'b1;
    i_ce = 1'b1;
    tick = 0;
    i_res = 1'b1;
    first = -1;
    for (int k = 1; k <= 260; k++) begin
      step();
      if (o_valid === 1'b1 && i_ready === 1'b1) begin
        if (first < 0) first = k;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL midreset_after: sample %h with empty scoreboard", o_data); end
        else begin
          exp_v = exp_q.pop_front();
          if (o_data !== exp_v || o_data !== 16'h8000) begin errors++; $display("FAIL midreset_after: got %h expected %h", o_data, exp_v); end
        end
      end
    end
    checks++; if (first != 193) begin errors++; $display("FAIL midreset_warmup: first valid at clk %0d expected 193", first); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_const(1'b0, 16'h0000, 0);
    test_const(1'b1, 16'hFFFF, 0);
    test_const(1'b0, 16'h8000, 1);
    test_dac_loopback();
    test_overrun();
    test_ce_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
